// File: rtl/pooling_unit.sv
// Max-pooling datapath: input word FIFO, 2/3-wide horizontal max, vertical max through a
// row FIFO, stride compaction and an output word FIFO on a valid/ready read port.

module pooling_unit_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;

  // Callers only assert push when there is room (or a pop frees it) and pop when non-empty.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

module pooling_unit #(
  parameter int NUM_PE         = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int CFG_WIDTH      = 3,
  parameter int CTRL_WIDTH     = 6,
  parameter int IN_FIFO_DEPTH  = 8,
  parameter int ROW_FIFO_DEPTH = 64,
  parameter int OUT_FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CFG_WIDTH-1:0]         cfg,
  input  logic [CTRL_WIDTH-1:0]        ctrl,
  input  logic                         row_first,
  output logic                         ready,
  input  logic [NUM_PE*DATA_WIDTH-1:0] write_data,
  input  logic                         write_req,
  output logic                         write_ready,
  output logic [NUM_PE*DATA_WIDTH-1:0] read_data,
  output logic                         read_req,
  input  logic                         read_ready,
  output logic [3:0]                   err
);
  localparam int HALF = NUM_PE / 2;
  localparam int ICW  = $clog2(IN_FIFO_DEPTH) + 1;
  localparam int RCW  = $clog2(ROW_FIFO_DEPTH) + 1;
  localparam int OCW  = $clog2(OUT_FIFO_DEPTH) + 1;
  localparam logic [DATA_WIDTH-1:0] LANE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef logic [NUM_PE-1:0][DATA_WIDTH-1:0] word_t;
  localparam word_t WORD_MIN = {NUM_PE{LANE_MIN}};

  function automatic logic [DATA_WIDTH-1:0] smax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  logic shift, pop, row_push, row_pop, mux_sel, pool_valid;
  assign {pool_valid, mux_sel, row_pop, row_push, pop, shift} = ctrl;

  logic           k3, stride2_eff;
  logic [ICW-1:0] in_count;
  logic [RCW-1:0] row_count;
  logic [OCW-1:0] out_count;
  logic           in_push, in_pop, row_do_push, row_do_pop, out_push, out_pop, out_enq_req;
  word_t          in_head, row_head, out_head, row_eff, h_new, v, sel, out_wdata;
  word_t          cur_q, cur_d, prev_q, prev_d, hmax_q, hmax_d, acc_q, acc_d;
  logic           half_q, half_d, stride2_q, stride2_d;
  logic [3:0]     err_q, err_d;
  logic [2*NUM_PE-1:0][DATA_WIDTH-1:0] win;

  assign k3          = cfg[2];
  // A stride picked up while half=0 is held until the compacted word completes.
  assign stride2_eff = half_q ? stride2_q : (cfg[1:0] == 2'd2);

  assign write_ready = (in_count != ICW'(IN_FIFO_DEPTH));
  assign in_push     = write_req && write_ready;
  assign in_pop      = pop && (in_count != '0);
  assign row_do_pop  = row_pop && (row_count != '0);
  assign row_do_push = row_push && ((row_count != RCW'(ROW_FIFO_DEPTH)) || row_do_pop);
  assign read_req    = (out_count != '0);
  assign out_pop     = read_req && read_ready;
  assign out_push    = out_enq_req && ((out_count != OCW'(OUT_FIFO_DEPTH)) || out_pop);
  assign ready       = (in_count != '0) && (out_count <= OCW'(OUT_FIFO_DEPTH - 2));
  assign read_data   = read_req ? out_head : '0;
  assign err         = err_q;

  pooling_unit_fifo #(.WIDTH(NUM_PE*DATA_WIDTH), .DEPTH(IN_FIFO_DEPTH)) u_in_fifo (
    .clk(clk), .reset(reset), .push(in_push), .pop(in_pop),
    .wdata(write_data), .head(in_head), .count(in_count)
  );

  pooling_unit_fifo #(.WIDTH(NUM_PE*DATA_WIDTH), .DEPTH(ROW_FIFO_DEPTH)) u_row_fifo (
    .clk(clk), .reset(reset), .push(row_do_push), .pop(row_do_pop),
    .wdata(v), .head(row_head), .count(row_count)
  );

  pooling_unit_fifo #(.WIDTH(NUM_PE*DATA_WIDTH), .DEPTH(OUT_FIFO_DEPTH)) u_out_fifo (
    .clk(clk), .reset(reset), .push(out_push), .pop(out_pop),
    .wdata(out_wdata), .head(out_head), .count(out_count)
  );

  // Window over {prev, cur}: prev lanes sit just left of lane 0.
  always_comb begin
    for (int n = 0; n < NUM_PE; n++) begin
      win[n]          = row_first ? LANE_MIN : prev_q[n];
      win[NUM_PE + n] = cur_q[n];
    end
    for (int n = 0; n < NUM_PE; n++) begin
      h_new[n] = smax(win[NUM_PE + n - 1], win[NUM_PE + n]);
      if (k3) h_new[n] = smax(h_new[n], win[NUM_PE + n - 2]);
    end
  end

  always_comb begin
    row_eff = (row_count == '0) ? WORD_MIN : row_head;
    for (int n = 0; n < NUM_PE; n++) begin
      v[n] = mux_sel ? hmax_q[n] : smax(hmax_q[n], row_eff[n]);
    end
    sel = '0;
    for (int m = 0; m < HALF; m++) begin
      sel[m] = k3 ? v[2*m] : v[2*m + 1];
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cur_d       = cur_q;
    prev_d      = prev_q;
    hmax_d      = hmax_q;
    acc_d       = acc_q;
    half_d      = half_q;
    stride2_d   = stride2_q;
    out_enq_req = 1'b0;
    out_wdata   = v;
    if (in_pop) cur_d = in_head;
    if (shift) begin
      prev_d = cur_q;
      hmax_d = h_new;
    end
    if (pool_valid) begin
      stride2_d = stride2_eff;
      if (!stride2_eff) begin
        out_enq_req = 1'b1;
      end else begin
        for (int m = 0; m < HALF; m++) begin
          if (half_q) acc_d[HALF + m] = sel[m];
          else        acc_d[m]        = sel[m];
        end
        half_d      = ~half_q;
        out_enq_req = half_q;
        out_wdata   = acc_d;
      end
    end
    err_d = err_q | {write_req && !write_ready,
                     row_push && !row_do_push,
                     row_pop && (row_count == '0),
                     pop && (in_count == '0)};
  end

  // NOTE: state registers use non-blocking assignments only; all next-state math lives above.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q     <= WORD_MIN;
      prev_q    <= WORD_MIN;
      hmax_q    <= WORD_MIN;
      acc_q     <= '0;
      half_q    <= 1'b0;
      stride2_q <= 1'b0;
      err_q     <= '0;
    end else begin
      cur_q     <= cur_d;
      prev_q    <= prev_d;
      hmax_q    <= hmax_d;
      acc_q     <= acc_d;
      half_q    <= half_d;
      stride2_q <= stride2_d;
      err_q     <= err_d;
    end
  end
endmodule

// File: tb/tb_pooling_unit.sv
// Directed and randomized checks of pooling_unit against a row-level max-pooling model.

module tb_pooling_unit;
  localparam int NP = 4;
  localparam int DW = 16;
  localparam int W  = NP * DW;
  localparam logic [5:0] C_SHIFT = 6'b000001;
  localparam logic [5:0] C_POP   = 6'b000010;
  localparam logic [5:0] C_RPUSH = 6'b000100;
  localparam logic [5:0] C_RPOP  = 6'b001000;
  localparam logic [5:0] C_MUX   = 6'b010000;
  localparam logic [5:0] C_PV    = 6'b100000;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   cfg;
  logic [5:0]   ctrl;
  logic         row_first;
  logic         ready;
  logic [W-1:0] write_data;
  logic         write_req;
  logic         write_ready;
  logic [W-1:0] read_data;
  logic         read_req;
  logic         read_ready;
  logic [3:0]   err;

  int checks = 0;
  int errors = 0;

  pooling_unit dut (
    .clk(clk), .reset(reset), .cfg(cfg), .ctrl(ctrl), .row_first(row_first),
    .ready(ready), .write_data(write_data), .write_req(write_req),
    .write_ready(write_ready), .read_data(read_data), .read_req(read_req),
    .read_ready(read_ready), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [5:0] c, input logic rf);
    ctrl      = c;
    row_first = rf;
    step();
    ctrl      = '0;
    row_first = 1'b0;
  endtask

  task automatic write_word(input logic [W-1:0] w);
    write_req  = 1'b1;
    write_data = w;
    step();
    write_req  = 1'b0;
  endtask

  // Pop one word, shift it into the window, then issue the finishing ctrl word.
  task automatic feed(input logic rf, input logic [5:0] last);
    cyc(C_POP, 1'b0);
    cyc(C_SHIFT, rf);
    cyc(last, 1'b0);
  endtask

  task automatic expect_word(input string tag, input logic [W-1:0] exp);
    check({tag, "_valid"}, 64'(read_req), 64'd1);
    check(tag, 64'(read_data), 64'(exp));
    read_ready = 1'b1;
    step();
    read_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] word_of(input int a, input int b, input int c, input int d);
    return {d[DW-1:0], c[DW-1:0], b[DW-1:0], a[DW-1:0]};
  endfunction

  // Horizontal max over a whole row of lanes; left of the row start counts as the minimum.
  function automatic void hrow(input int v[8], input bit k3, output int h[8]);
    for (int i = 0; i < 8; i++) begin
      h[i] = v[i];
      for (int d = 1; d <= (k3 ? 2 : 1); d++) begin
        if (i - d >= 0 && v[i-d] > h[i]) h[i] = v[i-d];
      end
    end
  endfunction

  initial begin
    int ra[8], rb[8], ha[8], hb[8], vv[8], tmp[8], h5[8];
    int ow[4];
    int q5[3][4];
    bit k3, s2;
    int k;

    reset = 1'b1; cfg = '0; ctrl = '0; row_first = 1'b0;
    write_data = '0; write_req = 1'b0; read_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_read_req", 64'(read_req), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_write_ready", 64'(write_ready), 64'd1);
    check("rst_err", 64'(err), 64'd0);
    check("rst_read_data", 64'(read_data), 64'd0);

    // Reset in the middle of a stride-2 word with input queued and an error flagged.
    cfg = 3'b010;
    for (int i = 0; i < 3; i++) write_word(word_of(i, i + 1, i + 2, i + 3));
    cyc(C_RPOP, 1'b0);
    cyc(C_PV | C_MUX, 1'b0);
    check("mid_ready", 64'(ready), 64'd1);
    check("mid_err", 64'(err), 64'h2);
    check("mid_half_open", 64'(read_req), 64'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst2_read_req", 64'(read_req), 64'd0);
    check("rst2_ready", 64'(ready), 64'd0);
    check("rst2_write_ready", 64'(write_ready), 64'd1);
    check("rst2_err", 64'(err), 64'd0);

    // K=2 stride 2; stride change mid-word must not take effect.
    cfg = 3'b010;
    write_word(word_of(3, 9, -4, 7));
    write_word(word_of(1, 2, 8, 0));
    feed(1'b1, C_PV | C_MUX);
    check("s2_first_half", 64'(read_req), 64'd0);
    cfg = 3'b001;
    feed(1'b0, C_PV | C_MUX);
    expect_word("s2_k2", word_of(9, 7, 2, 8));
    check("s2_drained", 64'(read_req), 64'd0);

    // Vertical max through the row FIFO, then the empty row FIFO reads as minimum.
    cfg = 3'b001;
    write_word(word_of(1, 2, 3, 4));
    write_word(word_of(5, 0, 0, 0));
    feed(1'b1, C_RPUSH | C_MUX);
    feed(1'b1, C_RPOP | C_PV);
    cyc(C_PV, 1'b0);
    expect_word("vmax", word_of(5, 5, 3, 4));
    expect_word("row_empty", word_of(5, 5, 0, 0));

    // K=3 stride 2.
    cfg = 3'b110;
    write_word(word_of(1, 2, 3, 4));
    write_word(word_of(5, 6, 7, 8));
    feed(1'b1, C_PV | C_MUX);
    feed(1'b0, C_PV | C_MUX);
    expect_word("s2_k3", word_of(1, 3, 5, 7));

    // Randomized two-row pooling against the row-level model.
    for (int t = 0; t < 8; t++) begin
      k3 = 1'($urandom_range(0, 1));
      s2 = 1'($urandom_range(0, 1));
      cfg = {k3, s2 ? 2'b10 : 2'b01};
      for (int i = 0; i < 8; i++) begin
        ra[i] = $signed(16'($urandom));
        rb[i] = $signed(16'($urandom));
      end
      write_word(word_of(ra[0], ra[1], ra[2], ra[3]));
      write_word(word_of(ra[4], ra[5], ra[6], ra[7]));
      feed(1'b1, C_RPUSH | C_MUX);
      feed(1'b0, C_RPUSH | C_MUX);
      write_word(word_of(rb[0], rb[1], rb[2], rb[3]));
      write_word(word_of(rb[4], rb[5], rb[6], rb[7]));
      feed(1'b1, C_RPOP | C_PV);
      feed(1'b0, C_RPOP | C_PV);
      hrow(ra, k3, ha);
      hrow(rb, k3, hb);
      for (int i = 0; i < 8; i++) vv[i] = (ha[i] > hb[i]) ? ha[i] : hb[i];
      if (s2) begin
        k = 0;
        for (int i = 0; i < 8; i++) begin
          if ((i % 2) == (k3 ? 0 : 1)) begin
            ow[k] = vv[i];
            k++;
          end
        end
        expect_word("rand_s2", word_of(ow[0], ow[1], ow[2], ow[3]));
      end else begin
        expect_word("rand_s1_w0", word_of(vv[0], vv[1], vv[2], vv[3]));
        expect_word("rand_s1_w1", word_of(vv[4], vv[5], vv[6], vv[7]));
      end
      check("rand_drained", 64'(read_req), 64'd0);
    end

    // Output back-pressure: ready drops once three words are waiting.
    cfg = 3'b001;
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 4; n++) q5[i][n] = $signed(16'($urandom));
      write_word(word_of(q5[i][0], q5[i][1], q5[i][2], q5[i][3]));
    end
    write_word(word_of(100, 0, 0, -50));
    for (int i = 0; i < 3; i++) begin
      feed(1'b1, C_PV | C_MUX);
      check($sformatf("bp_ready_%0d", i), 64'(ready), (i < 2) ? 64'd1 : 64'd0);
    end
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 8; n++) tmp[n] = (n < 4) ? q5[i][n] : 0;
      hrow(tmp, 1'b0, h5);
      expect_word($sformatf("bp_word_%0d", i), word_of(h5[0], h5[1], h5[2], h5[3]));
    end
    check("bp_ready_back", 64'(ready), 64'd1);

    // Error flags: empty pop, empty row pop, row overflow, input overflow.
    cyc(C_POP, 1'b0);
    cyc(C_POP, 1'b0);
    check("err_pop", 64'(err), 64'h1);
    cyc(C_RPOP, 1'b0);
    check("err_rpop", 64'(err), 64'h3);
    for (int i = 0; i < 64; i++) cyc(C_RPUSH | C_MUX, 1'b0);
    check("err_row_full_edge", 64'(err), 64'h3);
    cyc(C_RPUSH | C_MUX, 1'b0);
    check("err_row_push", 64'(err), 64'h7);
    for (int i = 0; i < 8; i++) begin
      write_word(word_of(100 + i, -i, 7 * i, -50 + i));
      check($sformatf("wr_ready_%0d", i), 64'(write_ready), (i < 7) ? 64'd1 : 64'd0);
    end
    write_word(word_of(-1, -1, -1, -1));
    check("err_all", 64'(err), 64'hf);
    check("full_read_req", 64'(read_req), 64'd0);
    check("full_ready", 64'(ready), 64'd1);
    feed(1'b1, C_PV | C_MUX);
    for (int n = 0; n < 8; n++) tmp[n] = 0;
    tmp[0] = 100; tmp[3] = -50;
    hrow(tmp, 1'b0, h5);
    expect_word("full_head_kept", word_of(h5[0], h5[1], h5[2], h5[3]));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("final_err", 64'(err), 64'd0);
    check("final_write_ready", 64'(write_ready), 64'd1);
    check("final_ready", 64'(ready), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
